// File: rtl/projectile_pool_if.sv
// Bus bundle for projectile_pool: frame/fire/player/barrier/pixel inputs and
// the pixel, hit and status outputs. master drives the inputs, slave is the pool.
interface projectile_pool_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int SLOTS       = 4
);
  localparam int T  = NUM_PLAYERS * SLOTS;
  localparam int OW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int CW = $clog2(T + 1);

  logic                      frame_tick;
  logic [NUM_PLAYERS-1:0]    fire;
  logic [2*NUM_PLAYERS-1:0]  dir;
  logic [10*NUM_PLAYERS-1:0] player_x;
  logic [10*NUM_PLAYERS-1:0] player_y;
  logic [9:0]                player_s;
  logic [9:0]                barrier_x;
  logic [9:0]                barrier_y;
  logic [9:0]                barrier_hh;
  logic [9:0]                barrier_lh;
  logic [9:0]                draw_x;
  logic [9:0]                draw_y;
  logic                      pixel_on;
  logic [OW-1:0]             pixel_owner;
  logic [NUM_PLAYERS-1:0]    hit;
  logic [CW-1:0]             active_count;
  logic                      busy;
  logic                      overrun;

  modport master (
    output frame_tick, fire, dir, player_x, player_y, player_s,
           barrier_x, barrier_y, barrier_hh, barrier_lh, draw_x, draw_y,
    input  pixel_on, pixel_owner, hit, active_count, busy, overrun
  );

  modport slave (
    input  frame_tick, fire, dir, player_x, player_y, player_s,
           barrier_x, barrier_y, barrier_hh, barrier_lh, draw_x, draw_y,
    output pixel_on, pixel_owner, hit, active_count, busy, overrun
  );
endinterface

// File: rtl/projectile_pool.sv
// Projectile pool: per-player bullet banks, one-slot-per-clock frame walk, spawn and hit report.
// Optional macro PROJECTILE_POOL_RICOCHET_EN: first screen-edge exit bounces instead of freeing.
module projectile_pool #(
  parameter int NUM_PLAYERS = 2,
  parameter int SLOTS       = 4,
  parameter int SPEED       = 4,
  parameter int BULLET_S    = 4,
  parameter int COOLDOWN    = 8,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480
) (
  input logic             Clk,
  input logic             Reset_n,
  projectile_pool_if.slave bus
);
  localparam int T  = NUM_PLAYERS * SLOTS;
  localparam int IW = (T > 1) ? $clog2(T) : 1;
  localparam int OW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int CW = $clog2(T + 1);
  localparam int DW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic signed [10:0] SW  = 11'(SCREEN_W);
  localparam logic signed [10:0] SH  = 11'(SCREEN_H);
  localparam logic signed [10:0] SPD = 11'(SPEED);
  localparam logic [11:0]        BS  = 12'(BULLET_S);

  typedef enum logic [1:0] {IDLE, WALK, SPAWN, DONE} state_e;

  state_e                 state_q;
  logic [IW-1:0]          walk_q;
  logic [T-1:0]           act_q;
  logic signed [10:0]     x_q [T];
  logic signed [10:0]     y_q [T];
  logic [1:0]             dir_q [T];
`ifdef PROJECTILE_POOL_RICOCHET_EN
  logic [T-1:0]           bnc_q;
`endif
  logic [NUM_PLAYERS-1:0] fire_q, pend_q, pend_d, hit_acc_q, hit_q;
  logic [DW-1:0]          cd_q [NUM_PLAYERS];
  logic [CW-1:0]          cnt_q;

  // Distance between an 11-bit signed coordinate and an unsigned 10-bit one.
  function automatic logic [11:0] absdiff(input logic signed [10:0] a, input logic [9:0] b);
    logic signed [11:0] d;
    d = 12'(a) - $signed({2'b00, b});
    return (d < 0) ? 12'(-d) : 12'(d);
  endfunction

  logic signed [10:0]     nx_w, ny_w;
  logic [1:0]             ndir_w;
  logic                   free_w, bounce_w, edge_w, found_w;
  logic [NUM_PLAYERS-1:0] hitv_w;
  logic [11:0]            plim_w;
  int                     owner_w;

  always_comb begin
    nx_w     = x_q[walk_q];
    ny_w     = y_q[walk_q];
    ndir_w   = dir_q[walk_q];
    free_w   = 1'b0;
    bounce_w = 1'b0;
    found_w  = 1'b0;
    hitv_w   = '0;
    plim_w   = 12'(bus.player_s) + BS;
    owner_w  = int'(walk_q) / SLOTS;
    case (dir_q[walk_q])
      2'b00:   ny_w = y_q[walk_q] - SPD;
      2'b01:   ny_w = y_q[walk_q] + SPD;
      2'b10:   nx_w = x_q[walk_q] - SPD;
      default: nx_w = x_q[walk_q] + SPD;
    endcase
    edge_w = (nx_w < 0) || (nx_w >= SW) || (ny_w < 0) || (ny_w >= SH);
    // Free reasons are prioritised: edge, then barrier, then lowest-index player.
`ifdef PROJECTILE_POOL_RICOCHET_EN
    if (edge_w && !bnc_q[walk_q]) begin
      bounce_w = 1'b1;
      ndir_w   = dir_q[walk_q] ^ 2'b01;
      if (nx_w < 0) nx_w = '0; else if (nx_w >= SW) nx_w = SW - 11'sd1;
      if (ny_w < 0) ny_w = '0; else if (ny_w >= SH) ny_w = SH - 11'sd1;
    end else if (edge_w) free_w = 1'b1;
`else
    if (edge_w) free_w = 1'b1;
`endif
    else if (absdiff(nx_w, bus.barrier_x) <= 12'(bus.barrier_lh) + BS &&
             absdiff(ny_w, bus.barrier_y) <= 12'(bus.barrier_hh) + BS) free_w = 1'b1;
    else begin
      for (int q = 0; q < NUM_PLAYERS; q++) begin
        if (!found_w && q != owner_w &&
            absdiff(nx_w, bus.player_x[10*q +: 10]) <= plim_w &&
            absdiff(ny_w, bus.player_y[10*q +: 10]) <= plim_w) begin
          found_w   = 1'b1;
          free_w    = 1'b1;
          hitv_w[q] = 1'b1;
        end
      end
    end
  end

  logic [NUM_PLAYERS-1:0] spawn_w, has_free_w;
  logic [IW-1:0]          sslot_w [NUM_PLAYERS];

  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      has_free_w[p] = 1'b0;
      sslot_w[p]    = '0;
      for (int s = SLOTS - 1; s >= 0; s--) begin
        if (!act_q[p*SLOTS + s]) begin
          has_free_w[p] = 1'b1;
          sslot_w[p]    = IW'(p*SLOTS + s);
        end
      end
      spawn_w[p] = has_free_w[p] && pend_q[p] && (cd_q[p] == '0);
    end
    pend_d = (pend_q & ~((state_q == SPAWN) ? spawn_w : '0)) | (bus.fire & ~fire_q);
  end

  logic          pix_on_w;
  logic [OW-1:0] pix_own_w;

  // Descending scan so the lowest-index covering slot sets the owner.
  always_comb begin
    pix_on_w  = 1'b0;
    pix_own_w = '0;
    for (int i = T - 1; i >= 0; i--) begin
      if (act_q[i] && absdiff(x_q[i], bus.draw_x) <= BS && absdiff(y_q[i], bus.draw_y) <= BS) begin
        pix_on_w  = 1'b1;
        pix_own_w = OW'(i / SLOTS);
      end
    end
  end

  assign bus.pixel_on     = pix_on_w;
  assign bus.pixel_owner  = pix_own_w;
  assign bus.hit          = hit_q;
  assign bus.active_count = cnt_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.overrun      = bus.frame_tick && (state_q != IDLE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      walk_q    <= '0;
      act_q     <= '0;
      fire_q    <= '0;
      pend_q    <= '0;
      hit_acc_q <= '0;
      hit_q     <= '0;
      cnt_q     <= '0;
`ifdef PROJECTILE_POOL_RICOCHET_EN
      bnc_q     <= '0;
`endif
      for (int i = 0; i < T; i++) begin
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        dir_q[i] <= '0;
      end
      for (int p = 0; p < NUM_PLAYERS; p++) cd_q[p] <= '0;
    end else begin
      fire_q <= bus.fire;
      pend_q <= pend_d;
      hit_q  <= '0;
      case (state_q)
        IDLE: if (bus.frame_tick) begin
          state_q <= WALK;
          walk_q  <= '0;
        end
        WALK: begin
          if (act_q[walk_q]) begin
            act_q[walk_q] <= !free_w;
            x_q[walk_q]   <= nx_w;
            y_q[walk_q]   <= ny_w;
            dir_q[walk_q] <= ndir_w;
`ifdef PROJECTILE_POOL_RICOCHET_EN
            if (bounce_w) bnc_q[walk_q] <= 1'b1;
`endif
            hit_acc_q <= hit_acc_q | hitv_w;
          end
          if (walk_q == IW'(T - 1)) state_q <= SPAWN;
          else walk_q <= walk_q + IW'(1);
        end
        // Hits are registered here so the pulse lines up with the DONE cycle.
        SPAWN: begin
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (spawn_w[p]) begin
              act_q[sslot_w[p]] <= 1'b1;
              x_q[sslot_w[p]]   <= $signed({1'b0, bus.player_x[10*p +: 10]});
              y_q[sslot_w[p]]   <= $signed({1'b0, bus.player_y[10*p +: 10]});
              dir_q[sslot_w[p]] <= bus.dir[2*p +: 2];
`ifdef PROJECTILE_POOL_RICOCHET_EN
              bnc_q[sslot_w[p]] <= 1'b0;
`endif
              cd_q[p] <= DW'(COOLDOWN);
            end
          end
          hit_q     <= hit_acc_q;
          hit_acc_q <= '0;
          state_q   <= DONE;
        end
        DONE: begin
          for (int p = 0; p < NUM_PLAYERS; p++)
            if (cd_q[p] != '0) cd_q[p] <= cd_q[p] - DW'(1);
          cnt_q   <= CW'($countones(act_q));
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_projectile_pool.sv
// Directed bench for projectile_pool: per-frame hit/count expectations go through a scoreboard queue.
module tb_projectile_pool;
  localparam int NP = 2;
  localparam int SL = 4;
  localparam int T  = NP * SL;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;

  projectile_pool_if #(.NUM_PLAYERS(NP), .SLOTS(SL)) bus ();
  projectile_pool #(.NUM_PLAYERS(NP), .SLOTS(SL)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0] hit;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_p(input int p, input int x, input int y, input logic [1:0] d);
    bus.player_x[10*p +: 10] = 10'(x);
    bus.player_y[10*p +: 10] = 10'(y);
    bus.dir[2*p +: 2]        = d;
  endtask

  task automatic set_fire(input logic v);
    @(posedge Clk);
    #1 bus.fire[0] = v;
  endtask

  task automatic chk_pix(input string tag, input int dx, input int dy, input logic on, input logic own);
    @(negedge Clk);
    bus.draw_x = 10'(dx);
    bus.draw_y = 10'(dy);
    #1;
    chk({tag, "_on"}, 32'(bus.pixel_on), 32'(on));
    chk({tag, "_own"}, 32'(bus.pixel_owner), 32'(own));
  endtask

  // One frame: queue the expectation, tick, optionally tick again while busy, wait for idle.
  task automatic do_frame(input logic [1:0] eh, input int ec, input bit inj);
    int n;
    exp_t e;
    e.hit = eh;
    e.cnt = ec;
    sb.push_back(e);
    @(posedge Clk);
    #1 bus.frame_tick = 1'b1;
    #1 chk("overrun_idle", 32'(bus.overrun), 0);
    @(posedge Clk);
    #1 bus.frame_tick = 1'b0;
    if (inj) begin
      @(posedge Clk);
      #1 bus.frame_tick = 1'b1;
      #2 chk("overrun_pulse", 32'(bus.overrun), 1);
      @(posedge Clk);
      #1 bus.frame_tick = 1'b0;
      #1 chk("overrun_clear", 32'(bus.overrun), 0);
    end
    n = 0;
    while (bus.busy && n < 4 * T) begin
      @(negedge Clk);
      n++;
    end
    chk("frame_done", 32'(bus.busy), 0);
  endtask

  // Monitor: counts busy cycles; the last one is DONE, where the scoreboard entry is popped.
  int   bcnt = 0;
  bit   cnt_chk = 1'b0;
  int   exp_cnt = 0;
  exp_t got_e;
  initial forever begin
    @(negedge Clk);
    if (!Reset_n) begin
      bcnt    = 0;
      cnt_chk = 1'b0;
    end else if (bus.busy) begin
      bcnt++;
      if (bcnt == T + 2) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          got_e = sb.pop_front();
          chk("hit_done", 32'(bus.hit), 32'(got_e.hit));
          exp_cnt = got_e.cnt;
          cnt_chk = 1'b1;
        end
      end else begin
        chk("hit_quiet", 32'(bus.hit), 0);
      end
    end else begin
      if (bcnt != 0) chk("busy_len", 32'(bcnt), T + 2);
      if (cnt_chk) chk("active_count", 32'(bus.active_count), 32'(exp_cnt));
      cnt_chk = 1'b0;
      bcnt    = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  x0, x1, y0;
    bit  a0, a1, al;
    logic [1:0] eh;
    bus.frame_tick = 1'b0;
    bus.fire       = '0;
    bus.dir        = '0;
    bus.player_x   = '0;
    bus.player_y   = '0;
    bus.player_s   = 10'd8;
    bus.barrier_x  = 10'd300;
    bus.barrier_y  = 10'd400;
    bus.barrier_hh = 10'd35;
    bus.barrier_lh = 10'd60;
    bus.draw_x     = 10'd100;
    bus.draw_y     = 10'd100;
    set_p(0, 100, 100, 2'b11);
    set_p(1, 200, 100, 2'b00);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_pixel_on", 32'(bus.pixel_on), 0);
    chk("rst_pixel_owner", 32'(bus.pixel_owner), 0);
    chk("rst_hit", 32'(bus.hit), 0);
    chk("rst_count", 32'(bus.active_count), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    @(posedge Clk);
    #1 Reset_n = 1'b1;

    // Spawn on the first edge, then motion and hold-without-respawn.
    set_fire(1'b1);
    do_frame(2'b00, 1, 1'b0);
    chk_pix("spawn_c", 100, 100, 1, 0);
    chk_pix("spawn_r", 104, 100, 1, 0);
    chk_pix("spawn_r_out", 105, 100, 0, 0);
    chk_pix("spawn_u_out", 100, 95, 0, 0);
    do_frame(2'b00, 1, 1'b0);
    chk_pix("move_r", 108, 100, 1, 0);
    chk_pix("move_r_out", 109, 100, 0, 0);
    chk_pix("move_l_out", 99, 100, 0, 0);
    do_frame(2'b00, 1, 1'b0);
    set_fire(1'b0);
    do_frame(2'b00, 1, 1'b0);

    // A fresh edge waits on the cooldown: four deferred frames, then the spawn.
    set_fire(1'b1);
    for (int k = 0; k < 4; k++) do_frame(2'b00, 1, 1'b0);
    chk_pix("cooldown_hold", 100, 100, 0, 0);
    do_frame(2'b00, 2, 1'b0);
    chk_pix("cooldown_spawn", 100, 100, 1, 0);
    chk_pix("first_at_132", 132, 100, 1, 0);
    set_fire(1'b0);

    // Both bullets fly right into player1 at (200,100).
    x0 = 132; x1 = 100; a0 = 1'b1; a1 = 1'b1;
    for (int k = 0; k < 40 && (a0 || a1); k++) begin
      eh = 2'b00;
      if (a0) begin x0 += 4; if (x0 >= 188) begin a0 = 1'b0; eh = 2'b10; end end
      if (a1) begin x1 += 4; if (x1 >= 188) begin a1 = 1'b0; eh = 2'b10; end end
      do_frame(eh, int'(a0) + int'(a1), 1'b0);
    end

    // Downward bullet into the barrier.
    set_p(1, 600, 400, 2'b00);
    set_p(0, 300, 300, 2'b01);
    set_fire(1'b1);
    do_frame(2'b00, 1, 1'b0);
    set_fire(1'b0);
    y0 = 300; al = 1'b1;
    for (int k = 0; k < 30 && al; k++) begin
      y0 += 4;
      al = (y0 < 361);
      do_frame(2'b00, int'(al), 1'b0);
    end

    // Left screen edge.
    set_p(0, 2, 50, 2'b10);
    set_fire(1'b1);
    do_frame(2'b00, 1, 1'b0);
    chk_pix("edge_spawn", 2, 50, 1, 0);
    set_fire(1'b0);
`ifdef PROJECTILE_POOL_RICOCHET_EN
    do_frame(2'b00, 1, 1'b0);
    chk_pix("bounce_at_0", 4, 50, 1, 0);
    chk_pix("bounce_out", 5, 50, 0, 0);
    x0 = 0; al = 1'b1;
    for (int k = 0; k < 200 && al; k++) begin
      x0 += 4;
      al = (x0 < 640);
      do_frame(2'b00, int'(al), 1'b0);
    end
`else
    do_frame(2'b00, 0, 1'b0);
    chk_pix("edge_gone", 2, 50, 0, 0);
`endif
    for (int k = 0; k < 8; k++) do_frame(2'b00, 0, 1'b0);

    // Fill player0's bank; the fifth spawn waits for slot 0 to leave the top edge.
    set_p(0, 50, 160, 2'b00);
    for (int k = 0; k < 42; k++) begin
      set_fire(1'b0);
      set_fire(1'b1);
      if (k == 1) set_p(0, 50, 460, 2'b00);
      do_frame(2'b00, (k < 8) ? 1 : (k < 16) ? 2 : (k < 24) ? 3 : 4, 1'b0);
      if (k == 40) begin
        chk_pix("full_pending", 50, 460, 0, 0);
        chk_pix("slot0_at_top", 50, 0, 1, 0);
      end
    end
    chk_pix("respawn", 50, 460, 1, 0);
    chk_pix("slot0_gone", 50, 0, 0, 0);

    // frame_tick while busy is dropped.
    do_frame(2'b00, 4, 1'b1);

    // Reset in the middle of a walk.
    @(posedge Clk);
    #1 bus.frame_tick = 1'b1;
    @(posedge Clk);
    #1 bus.frame_tick = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b0;
    bus.fire = '0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_count", 32'(bus.active_count), 0);
    chk_pix("midrst_pix", 50, 456, 0, 0);
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    do_frame(2'b00, 0, 1'b0);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
